axi_boot_loader: RTL
====================

Name: axi_boot_loader

Overview:
- Synthesizable AXI4 write initiator; fills the chip SRAM with the boot image at run time instead of by simulation backdoor.
- Accepts a little-endian byte stream (valid/ready, with a last flag).
- Packs bytes into 64-bit words and issues single-beat INCR writes to the SRAM AXI slave.
- Holds the core in reset until the image has fully landed; reports done or error.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of the first image word; must be 8-byte aligned.
- AW, 32, AXI address width.
- MAX_BYTES, 131072, image size limit in bytes (16384 x 64-bit words).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- byte_valid  in  1  input byte present
- byte_data  in  8  input byte
- byte_last  in  1  final byte of the image; qualified by byte_valid
- byte_ready  out  1  loader accepts a byte this cycle
- M_AXI_AWADDR  out  AW  write address
- M_AXI_AWLEN  out  8  constant 0
- M_AXI_AWSIZE  out  3  constant 3'b011
- M_AXI_AWBURST  out  2  constant 2'b01
- M_AXI_AWVALID  out  1  address valid
- M_AXI_AWREADY  in  1  address accepted
- M_AXI_WDATA  out  64  write data
- M_AXI_WSTRB  out  8  byte strobes
- M_AXI_WLAST  out  1  constant 1
- M_AXI_WVALID  out  1  data valid
- M_AXI_WREADY  in  1  data accepted
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  response valid
- M_AXI_BREADY  out  1  response accepted
- core_hold  out  1  keeps the core in reset while high
- load_done  out  1  sticky; image written with no error
- load_err  out  1  sticky; error seen

Behaviour:
Reset values (asynchronous):
- state=COLLECT, lane=0, word/strb=0, addr=BASE_ADDR, byte count=0.
- AWVALID=WVALID=BREADY=0; byte_ready=1; core_hold=1; load_done=load_err=0.

COLLECT:
- byte_ready=1. A byte transfers when byte_valid&byte_ready.
- The byte goes into word[8*lane +: 8]; strb[lane] is set; lane increments.
- Transition to ISSUE when lane reaches 7, or on byte_last.
- The word in flight is the word including that accepted byte.

ISSUE:
- byte_ready=0. AWVALID and WVALID rise together, the cycle after the transition.
- AWADDR=addr, WDATA=word, WSTRB=strb.
- Each valid drops independently after its own handshake; AW and W may complete in either order or the same cycle.
- AXI rule: neither valid depends on the matching ready.
- When both handshakes are done, go to RESP.

RESP:
- BREADY=1.
- On BVALID with BRESP==OKAY:
  - addr += 8; clear lane, word, strb.
  - If the word held the last byte, go to DONE; otherwise go to COLLECT.
- On BVALID with BRESP!=OKAY: go to ERR.

DONE:
- byte_ready=0, load_done=1, core_hold=0. Terminal until RST.

ERR:
- byte_ready=0, load_err=1, core_hold=1. Terminal until RST.

Boundaries:
- Partial final word: only the received lanes are strobed. Example: 3 bytes give WSTRB=8'h07, with zeros in the unused WDATA lanes.
- byte_last on lane 7: a single flush, not an extra empty write.
- Byte count limit: if accepting a byte would push the count past MAX_BYTES, that byte is dropped, no write is issued, and the loader goes to ERR the next cycle.
- byte_valid while byte_ready=0: ignored; the source must hold the byte.
- addr arithmetic wraps modulo 2^AW with no error; MAX_BYTES bounds it in practice.
- RST mid-transaction: valids drop immediately. Slave recovery is the slave's responsibility.

Latency:
- The last byte of a word is accepted at cycle N.
- AW/W valid at N+1.
- With zero-wait ready and BVALID, the next byte is accepted at N+3.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (32 bits).
  - checksum is the modulo-2^32 sum of every accepted byte, zero-extended; it is reset to 0.
  - Adds input port expect_sum (32 bits).
  - On the OKAY response to the last word: go to DONE if checksum==expect_sum, else ERR.
- When undefined: neither port exists, and the last word goes straight to DONE.

Test Plan:
- 16 bytes 0x00..0x0F, last on byte 15, zero-wait slave -> two writes:
  - 0x80000000 with data 64'h0706050403020100, strb FF.
  - 0x80000008 with data 64'h0F0E0D0C0B0A0908, strb FF.
  - Then load_done=1 and core_hold=0.
- 3 bytes AA BB CC, last on byte 3 -> one write, WDATA=64'h0000000000CCBBAA, WSTRB=8'h07, load_done=1.
- AWREADY delayed 4 cycles with WREADY immediate (then reversed) -> exactly one AW and one W handshake, BREADY only after both; correct data.
- BRESP=2'b10 on the second word -> load_err=1, byte_ready=0, core_hold=1, no third write.
- RST asserted while in ISSUE -> outputs return to reset values the same cycle. A reload then starts at BASE_ADDR.
- BOOT_CHECKSUM_EN, bytes 01 02 03, expect_sum=6 -> load_done=1. With expect_sum=7 -> load_err=1.

Source files
------------

// File: rtl/axi_boot_loader.sv
// axi_boot_loader: AXI4 write initiator that packs a little-endian byte
// stream into 64-bit words and writes them to SRAM as single-beat INCR
// bursts, holding the core in reset until the whole image has landed.
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   byte_valid/ready     byte stream handshake
//   byte_data/last       stream payload and end-of-image flag
//   M_AXI_AW*            write address channel (AWLEN=0, 8-byte, INCR)
//   M_AXI_W*             write data channel (WLAST=1)
//   M_AXI_B*             write response channel
//   core_hold            high keeps the core in reset
//   load_done, load_err  sticky completion / error flags
//
// Optional: define BOOT_CHECKSUM_EN to add checksum (out) and
// expect_sum (in); the last word then completes only on a sum match.

module axi_boot_loader #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
    parameter int              MAX_BYTES = 131072
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          byte_last,
    output logic          byte_ready,
`ifdef BOOT_CHECKSUM_EN
    output logic [31:0]   checksum,
    input  logic [31:0]   expect_sum,
`endif
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic [7:0]    M_AXI_AWLEN,
    output logic [2:0]    M_AXI_AWSIZE,
    output logic [1:0]    M_AXI_AWBURST,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [63:0]   M_AXI_WDATA,
    output logic [7:0]    M_AXI_WSTRB,
    output logic          M_AXI_WLAST,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_RESP,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      lane_q, lane_d;
    logic [63:0]     word_q, word_d;
    logic [7:0]      strb_q, strb_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            byte_ready_q, byte_ready_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            final_ok;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]     sum_q, sum_d;
`endif

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        word_d       = word_q;
        strb_d       = strb_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        byte_ready_d = byte_ready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        hold_d       = hold_q;
        done_d       = done_q;
        err_d        = err_q;
        final_ok     = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        sum_d        = sum_q;
        final_ok     = (sum_q == expect_sum);
`endif

        unique case (state_q)
            S_COLLECT: begin
                if (byte_valid && byte_ready_q) begin
                    if (cnt_q == CW'(MAX_BYTES)) begin
                        // Over the image limit: drop the byte, no write.
                        state_d      = S_ERR;
                        byte_ready_d = 1'b0;
                        err_d        = 1'b1;
                    end else begin
                        word_d[8*lane_q +: 8] = byte_data;
                        strb_d[lane_q]        = 1'b1;
                        lane_d                = lane_q + 3'd1;
                        cnt_d                 = cnt_q + CW'(1);
`ifdef BOOT_CHECKSUM_EN
                        sum_d = sum_q + {24'd0, byte_data};
`endif
                        // A last byte on lane 7 still gives one flush.
                        if (lane_q == 3'd7 || byte_last) begin
                            state_d      = S_ISSUE;
                            last_d       = byte_last;
                            byte_ready_d = 1'b0;
                            awvalid_d    = 1'b1;
                            wvalid_d     = 1'b1;
                        end
                    end
                end
            end

            S_ISSUE: begin
                // Each channel retires on its own handshake.
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_RESP;
                    bready_d = 1'b1;
                end
            end

            S_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP == 2'b00) begin
                        addr_d = addr_q + AW'(8);
                        lane_d = 3'd0;
                        word_d = 64'd0;
                        strb_d = 8'd0;
                        if (!last_q) begin
                            state_d      = S_COLLECT;
                            byte_ready_d = 1'b1;
                        end else if (final_ok) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            S_DONE: begin
            end

            S_ERR: begin
            end

            default: begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_COLLECT;
            lane_q       <= 3'd0;
            word_q       <= 64'd0;
            strb_q       <= 8'd0;
            addr_q       <= BASE_ADDR;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            byte_ready_q <= 1'b1;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            strb_q       <= strb_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            byte_ready_q <= byte_ready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign byte_ready    = byte_ready_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b011;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = word_q;
    assign M_AXI_WSTRB   = strb_q;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign core_hold     = hold_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
`ifdef BOOT_CHECKSUM_EN
    assign checksum      = sum_q;
`endif

endmodule
